// File: rtl/serial_addsub_pkg.sv
// rtl/serial_addsub_pkg.sv - shared types and constants for the bit-serial adder/subtractor
//   state_t   : FSM state encoding (IDLE, RUN, DONE)
//   CNT_W     : bit-counter width for a given operand width
//   WIDTH_MIN : smallest supported operand width
//   WIDTH_MAX : largest supported operand width
package serial_addsub_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int CNT_W(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/serial_addsub_fa_cell.sv
// rtl/serial_addsub_fa_cell.sv - combinational 1-bit full adder (module fa_cell)
//   a, b : operand bits
//   cin  : carry in
//   s    : sum bit
//   cout : carry out (majority of a, b, cin)
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - bit-serial adder/subtractor, LSB first, start/busy/done handshake
//   clk, rst        : clock, asynchronous active-high reset
//   start           : request, sampled only in IDLE; sub/a/b captured with it
//   sub             : 0 = a+b, 1 = a-b (a + ~b + 1)
//   a, b            : WIDTH-bit operands
//   busy            : high while bits are being processed
//   done            : one-cycle pulse, result/carry_out valid
//   result          : sum/difference, held until the next operation completes
//   carry_out       : add: carry out of MSB; sub: 1 = no borrow
//   overflow        : signed overflow, present only when OVERFLOW_FLAG_EN is defined
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
`ifdef OVERFLOW_FLAG_EN
    ,
    output logic             overflow
`endif
);

    localparam int CW = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
        $error("serial_addsub: WIDTH out of range");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds the first WIDTH-1 sum bits; the final bit is merged in directly
    // when the result register is loaded.
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic             c_q, c_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             done_q, done_d;
`ifdef OVERFLOW_FLAG_EN
    logic             overflow_q, overflow_d;
`endif

    logic fa_s;
    logic fa_cout;

    fa_cell u_fa (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (c_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        done_d      = 1'b0;
`ifdef OVERFLOW_FLAG_EN
        overflow_d  = overflow_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = sub ? ~b : b;
                    // Subtraction's +1 enters as the initial carry.
                    c_d     = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d             = a_sh_q >> 1;
                b_sh_d             = b_sh_q >> 1;
                res_sh_d           = res_sh_q >> 1;
                res_sh_d[WIDTH-2]  = fa_s;
                c_d                = fa_cout;
                cnt_d              = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    result_d    = {fa_s, res_sh_q};
                    carry_out_d = fa_cout;
`ifdef OVERFLOW_FLAG_EN
                    // c_q is the carry into the MSB on the last bit.
                    overflow_d  = c_q ^ fa_cout;
`endif
                    state_d     = DONE;
                end
            end
            DONE: begin
                // done is registered, so the pulse appears on the port the
                // cycle after DONE, when the FSM is already back in IDLE.
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            overflow_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            done_q      <= done_d;
`ifdef OVERFLOW_FLAG_EN
            overflow_q  <= overflow_d;
`endif
        end
    end

    assign busy      = (state_q == RUN);
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
`ifdef OVERFLOW_FLAG_EN
    assign overflow  = overflow_q;
`endif

endmodule
